// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder
//   Registered N:W priority encoder with a valid/ready handshake on both sides.
//   MODE 0 picks the highest set request index. MODE 1 is round-robin: the search
//   starts at ptr and counts down, wrapping from 0 back to N-1.
//   The result goes into a single output register. Because in_ready is high whenever
//   the register is empty or being popped, the block can deliver one result per clock.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request vector i is valid this cycle
//   in_ready   block can accept i this cycle
//   i          N-bit request vector
//   out_valid  y / grant / zero hold a result
//   out_ready  consumer takes the result this cycle
//   y          encoded winning index (0 when no request is set)
//   grant      one-hot of the winner, all zero when zero = 1
//   zero       the accepted request vector was all zeros
module rr_priority_encoder #(
  parameter int unsigned N    = 8,
  parameter int unsigned W    = $clog2(N),
  parameter int unsigned MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic [N-1:0] grant,
  output logic         zero
);

  logic         out_valid_q;
  logic [W-1:0] y_q;
  logic [N-1:0] grant_q;
  logic         zero_q;
  logic [W-1:0] ptr_q;

  logic         accept;
  logic         pop;
  logic         win_found;
  logic [W-1:0] win_idx;
  logic [N-1:0] grant_d;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid_q && out_ready;

  // Winner search. In round-robin mode each line gets a rank equal to its distance
  // below ptr (modulo N), and the set line with the smallest rank wins.
  always_comb begin
    int best_rank;
    int rank;
    win_found = 1'b0;
    win_idx   = '0;
    best_rank = int'(N);
    rank      = 0;
    if (MODE == 0) begin
      // Ascending scan, so a later (higher) set bit overrides an earlier one.
      for (int j = 0; j < int'(N); j++) begin
        if (i[j]) begin
          win_found = 1'b1;
          win_idx   = W'(j);
        end
      end
    end else begin
      for (int j = 0; j < int'(N); j++) begin
        rank = (int'(ptr_q) >= j) ? (int'(ptr_q) - j) : (int'(ptr_q) + int'(N) - j);
        if (i[j] && (rank < best_rank)) begin
          best_rank = rank;
          win_found = 1'b1;
          win_idx   = W'(j);
        end
      end
    end
  end

  always_comb begin
    grant_d = '0;
    if (win_found) begin
      grant_d[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      grant_q     <= '0;
      zero_q      <= 1'b0;
      ptr_q       <= W'(N - 1);
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        y_q         <= win_idx;
        grant_q     <= grant_d;
        zero_q      <= !win_found;
        // ptr moves only when a real request is accepted, never on a pop.
        if ((MODE == 1) && win_found) begin
          ptr_q <= (win_idx == '0) ? W'(N - 1) : (win_idx - W'(1));
        end
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign grant     = grant_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed bench for rr_priority_encoder. It instantiates three designs: fixed
// priority with N=4, round-robin with N=4, and round-robin with N=5. All three share
// the clock and the reset.
module tb_rr_priority_encoder;

  logic clk;
  logic rst_n;

  // a: MODE0 N=4
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_zero;
  logic [3:0] a_i, a_grant;
  logic [1:0] a_y;
  // b: MODE1 N=4
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_zero;
  logic [3:0] b_i, b_grant;
  logic [1:0] b_y;
  // c: MODE1 N=5
  logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_zero;
  logic [4:0] c_i, c_grant;
  logic [2:0] c_y;

  int n_tests = 0;
  int n_fail  = 0;

  rr_priority_encoder #(.N(4), .MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .i(a_i),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .y(a_y), .grant(a_grant),
    .zero(a_zero)
  );
  rr_priority_encoder #(.N(4), .MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .i(b_i),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .y(b_y), .grant(b_grant),
    .zero(b_zero)
  );
  rr_priority_encoder #(.N(5), .MODE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .i(c_i),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .y(c_y), .grant(c_grant),
    .zero(c_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for the next rising edge, then let the registers settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 0; a_out_ready = 1; a_i = '0;
    b_in_valid = 0; b_out_ready = 1; b_i = '0;
    c_in_valid = 0; c_out_ready = 1; c_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_y",         a_y, 0);
    chk("rst_grant",     a_grant, 0);
    chk("rst_zero",      a_zero, 0);
    chk("rst_in_ready",  a_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed-priority encoding, one request per clock
    a_in_valid = 1; a_i = 4'b0001; tick();
    chk("m0_0001_y", a_y, 0); chk("m0_0001_g", a_grant, 4'b0001);
    chk("m0_valid", a_out_valid, 1);
    a_i = 4'b0010; tick();
    chk("m0_0010_y", a_y, 1); chk("m0_0010_g", a_grant, 4'b0010);
    a_i = 4'b0110; tick();
    chk("m0_0110_y", a_y, 2); chk("m0_0110_g", a_grant, 4'b0100);
    a_i = 4'b1010; tick();
    chk("m0_1010_y", a_y, 3); chk("m0_1010_g", a_grant, 4'b1000);
    chk("m0_zero_clr", a_zero, 0);

    // An all-zero request still produces a result
    a_i = 4'b0000; tick();
    chk("m0_z_valid", a_out_valid, 1); chk("m0_z_zero", a_zero, 1);
    chk("m0_z_y", a_y, 0); chk("m0_z_g", a_grant, 0);
    // Popping with no new accept clears out_valid and keeps the data
    a_in_valid = 0; tick();
    chk("m0_pop_valid", a_out_valid, 0); chk("m0_pop_zero_hold", a_zero, 1);

    // Backpressure: the held result stays stable and in_ready is low
    a_in_valid = 1; a_i = 4'b0100; tick();
    chk("bp_y0", a_y, 2);
    a_out_ready = 0; a_i = 4'b1000; #1;
    chk("bp_in_ready_lo", a_in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_y", a_y, 2);
      chk("bp_hold_valid", a_out_valid, 1);
      chk("bp_hold_g", a_grant, 4'b0100);
      chk("bp_hold_rdy", a_in_ready, 0);
    end
    a_out_ready = 1; #1;
    chk("bp_in_ready_hi", a_in_ready, 1);
    tick();
    chk("bp_rel_y", a_y, 3); chk("bp_rel_g", a_grant, 4'b1000);
    a_in_valid = 0; tick();

    // Round-robin with N=4 and all requests set: results come back to back
    b_in_valid = 1; b_i = 4'b1111;
    tick(); chk("rr4_y0", b_y, 3); chk("rr4_g0", b_grant, 4'b1000);
    tick(); chk("rr4_y1", b_y, 2); chk("rr4_v1", b_out_valid, 1);
    tick(); chk("rr4_y2", b_y, 1); chk("rr4_v2", b_out_valid, 1);
    tick(); chk("rr4_y3", b_y, 0); chk("rr4_g3", b_grant, 4'b0001);
    tick(); chk("rr4_y4", b_y, 3);
    tick(); chk("rr4_y5", b_y, 2);
    b_i = 4'b0101;
    tick(); chk("rr4_0101_a", b_y, 0);
    tick(); chk("rr4_0101_b", b_y, 2); chk("rr4_0101_g", b_grant, 4'b0100);

    // Asynchronous reset asserted between clock edges
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", b_out_valid, 0);
    chk("arst_y", b_y, 0);
    chk("arst_g", b_grant, 0);
    b_in_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    b_in_valid = 1; b_i = 4'b1111;
    tick(); chk("arst_first_y", b_y, 3);
    b_in_valid = 0; tick();

    // Round-robin with N=5 (not a power of two), including a zero accept mid-sequence
    c_in_valid = 1; c_i = 5'b11111;
    tick(); chk("rr5_y4", c_y, 4); chk("rr5_g4", c_grant, 5'b10000);
    tick(); chk("rr5_y3", c_y, 3);
    tick(); chk("rr5_y2", c_y, 2);
    c_i = 5'b00000;
    tick(); chk("rr5_zero", c_zero, 1); chk("rr5_zero_y", c_y, 0);
    c_i = 5'b11111;
    tick(); chk("rr5_y1", c_y, 1); chk("rr5_zclr", c_zero, 0);
    tick(); chk("rr5_y0", c_y, 0);
    tick(); chk("rr5_wrap", c_y, 4);
    // Backpressure must not advance the pointer
    c_out_ready = 0;
    tick(); chk("rr5_bp_a", c_y, 4);
    tick(); chk("rr5_bp_b", c_y, 4);
    c_out_ready = 1;
    tick(); chk("rr5_bp_next", c_y, 3);
    c_in_valid = 0;
    tick(); chk("rr5_drain", c_out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
